// File: rtl/relu_layer_ctrl_pkg.sv
// Shared definitions for the ReLU layer controller: FSM encoding and
// the floating-point word layout.
package relu_layer_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int FP32_SIGN_BIT      = 31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/relu_layer_ctrl_relu.sv
// Combinational element ReLU: any word with the sign bit set (including
// -0.0 and negative NaN) becomes all-zero, everything else passes through.
module relu_layer_ctrl_relu
    import relu_layer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SIGN_BIT   = FP32_SIGN_BIT
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    assign data_o = data_i[SIGN_BIT] ? '0 : data_i;

endmodule

// File: rtl/relu_layer_ctrl.sv
// Streams a feature map through ReLU: one read per cycle from src_base,
// one registered write per cycle to dst_base, counting zeroed elements.
module relu_layer_ctrl
    import relu_layer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   neg_count
);

    localparam int SIGN_IDX = DATA_WIDTH - (DEFAULT_DATA_WIDTH - FP32_SIGN_BIT);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     len_q;
    logic [ADDR_WIDTH:0]     rd_idx_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic [ADDR_WIDTH:0]     neg_count_q;
    logic                    rd_vld_q;
    logic                    wr_en_q;
    logic [DATA_WIDTH-1:0]   relu_out;
    logic                    start_ok;
    logic                    last_rd;
    logic                    last_wr;

    relu_layer_ctrl_relu #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGN_BIT   (SIGN_IDX)
    ) u_relu (
        .data_i (rd_data),
        .data_o (relu_out)
    );

    assign start_ok = start && (state_q == ST_IDLE);
    assign last_rd  = (rd_idx_q == len_q - 1'b1);
    // The final write is on the bus once nothing is left in the read pipe.
    assign last_wr  = wr_en_q && !rd_vld_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (length == '0) ? ST_DONE : ST_READ;
            ST_READ:  if (last_rd) state_d = ST_DRAIN;
            ST_DRAIN: if (last_wr) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_READ:  begin rd_en = 1'b1; busy = 1'b1; end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  begin busy = 1'b1; done = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= '0;
            rd_idx_q    <= '0;
            rd_addr_q   <= '0;
            wr_ptr_q    <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            neg_count_q <= '0;
            rd_vld_q    <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            // rd_data is valid the cycle after a read strobe
            rd_vld_q <= (state_q == ST_READ);
            wr_en_q  <= rd_vld_q;

            if (start_ok) begin
                len_q       <= length;
                rd_idx_q    <= '0;
                rd_addr_q   <= src_base;
                wr_ptr_q    <= dst_base;
                neg_count_q <= '0;
            end else if (state_q == ST_READ) begin
                rd_idx_q  <= rd_idx_q + 1'b1;
                rd_addr_q <= rd_addr_q + 1'b1;
            end

            if (rd_vld_q) begin
                wr_data_q <= relu_out;
                wr_addr_q <= wr_ptr_q;
                wr_ptr_q  <= wr_ptr_q + 1'b1;
                if (rd_data[SIGN_IDX]) begin
                    neg_count_q <= neg_count_q + 1'b1;
                end
            end
        end
    end

    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign neg_count = neg_count_q;

endmodule

// File: tb/tb_relu_layer_ctrl.sv
// Self-checking bench for relu_layer_ctrl: random layers against a
// cycle-indexed reference model of the read/write schedule.
module tb_relu_layer_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   length = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic [AW:0]   neg_count;

    logic [DW-1:0] mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    int model_neg = 0;

    relu_layer_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .length    (length),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .neg_count (neg_count)
    );

    always #5 clk = ~clk;

    // Feature-map buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
        return (x >= 32'h8000_0000) ? 32'h0 : x;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFC0_0000;
            2:       return 32'h0000_0000;
            3:       return 32'h7FC0_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_neg"}, neg_count, 0);
    endtask

    // Called #1 after an edge; start is high for cycle 0. Returns during
    // the done cycle. poke pulses ignored starts mid-run and on done.
    task automatic run_layer(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                             input int len, input bit poke);
        int last;
        int wi;
        logic [DW-1:0] elt;
        src_base = src;
        dst_base = dst;
        length   = len[AW:0];
        start    = 1'b1;
        model_neg = 0;
        last = (len == 0) ? 1 : len + 3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            wi = c - 3;
            check("rd_en", rd_en, (c <= len) ? 1 : 0);
            if (c <= len) check("rd_addr", rd_addr, (int'(src) + c - 1) % DEPTH);
            check("wr_en", wr_en, (c >= 3 && c <= len + 2) ? 1 : 0);
            if (c >= 3 && c <= len + 2) begin
                elt = mem[(int'(src) + wi) % DEPTH];
                if (elt >= 32'h8000_0000) model_neg++;
                check("wr_addr", wr_addr, (int'(dst) + wi) % DEPTH);
                check("wr_data", wr_data, relu_ref(elt));
            end
            check("neg_count", neg_count, model_neg);
            check("busy", busy, 1);
            check("done", done, (c == last) ? 1 : 0);
            if (poke && (c == 2 || c == last)) begin
                start    = 1'b1;
                src_base = src + 10'd7;
                dst_base = dst + 10'd9;
                length   = 11'd5;
            end
            if (c != last) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    // Advance one cycle and confirm the controller sits idle, holding neg_count.
    task automatic idle_cycle();
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_rd_en", rd_en, 0);
        check("idle_wr_en", wr_en, 0);
        check("idle_neg_hold", neg_count, model_neg);
    endtask

    initial begin
        fill_mem();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Worked example with one negative element.
        mem[0] = 32'hC126_6666;
        mem[1] = 32'h40B3_3333;
        mem[2] = 32'h0000_0002;
        run_layer(10'h000, 10'h100, 3, 1'b0);
        check("ex_neg_count", neg_count, 1);
        idle_cycle();

        // Empty layer.
        run_layer(10'h055, 10'h0AA, 0, 1'b0);
        check("len0_neg", neg_count, 0);
        idle_cycle();

        // Read address wrap.
        fill_mem();
        run_layer(10'h3FE, 10'h3FF, 4, 1'b0);
        idle_cycle();

        // -0.0 and negative NaN both zeroed.
        mem[10'h200] = 32'h8000_0000;
        mem[10'h201] = 32'hFFC0_0000;
        run_layer(10'h200, 10'h010, 2, 1'b0);
        check("negzero_nan_neg", neg_count, 2);
        idle_cycle();

        // Ignored starts mid-run and on done; next cycle start accepted.
        fill_mem();
        run_layer(10'h123, 10'h321, 6, 1'b1);
        @(posedge clk); #1;
        check("after_done_idle", busy, 0);
        run_layer(10'h040, 10'h080, 5, 1'b0);
        idle_cycle();

        // Reset during cycle 2 of a length-8 run.
        fill_mem();
        src_base = 10'h000;
        dst_base = 10'h300;
        length   = 11'd8;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_rd_en_c2", rd_en, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort");
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("abort_no_wr", wr_en, 0);
            check("abort_no_done", done, 0);
            check("abort_no_rd", rd_en, 0);
        end
        run_layer(10'h010, 10'h300, 8, 1'b0);
        idle_cycle();

        // Full-size layer.
        fill_mem();
        run_layer(10'h2A0, 10'h155, DEPTH, 1'b0);
        idle_cycle();

        // Random layers, some back-to-back, some with ignored starts.
        for (int r = 0; r < 25; r++) begin
            fill_mem();
            run_layer(AW'($urandom), AW'($urandom), $urandom_range(0, 40), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                idle_cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
